// File: rtl/ga_eval_sequencer.sv
// ---------------------------------------------------------------------------
// ga_eval_sequencer
//
// Fitness-evaluation controller for an evolved logic array. After an accepted
// start it walks every input vector 0 .. 2^IN_W-1 into the array under test.
// Each vector is held for SETTLE cycles and then the array's response is
// sampled. The response is compared bitwise against the expected truth table.
// The number of matching bits is accumulated as fitness, and the observed
// truth table is captured for readback.
//
// Ports
//   clk          system clock (single domain)
//   reset        synchronous, active-high reset
//   start        one-cycle request to begin an evaluation (IDLE only)
//   abort        cancels an evaluation in progress
//   expected_tt  expected outputs, slice [v*OUT_W +: OUT_W] is vector v
//   dut_in       registered vector driven to the array under test
//   dut_out      array response, combinational from dut_in
//   result_tt    captured array outputs, same slicing as expected_tt
//   fitness      count of matching output bits
//   perfect      fitness equals 2^IN_W*OUT_W (valid after done)
//   busy         evaluation in progress (APPLY / SAMPLE)
//   done         one-cycle completion pulse
// ---------------------------------------------------------------------------
module ga_eval_sequencer #(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 2,
    parameter int SETTLE = 8,
    parameter int FIT_W  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [(1<<IN_W)*OUT_W-1:0]    expected_tt,
    output logic [IN_W-1:0]               dut_in,
    input  logic [OUT_W-1:0]              dut_out,
    output logic [(1<<IN_W)*OUT_W-1:0]    result_tt,
    output logic [FIT_W-1:0]              fitness,
    output logic                          perfect,
    output logic                          busy,
    output logic                          done
);

    localparam int NVEC    = 1 << IN_W;
    localparam int TT_W    = NVEC * OUT_W;
    localparam int CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int MATCH_W = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     settle_cnt;
    logic                 settle_hit;
    logic                 last_vec;
    logic                 accept_start;
    logic [OUT_W-1:0]     exp_slice;
    logic [MATCH_W-1:0]   match;

    assign settle_hit   = (settle_cnt == CNT_W'(SETTLE - 1));
    assign last_vec     = (dut_in == IN_W'(NVEC - 1));
    // abort has priority over a simultaneous start in IDLE.
    assign accept_start = start && !abort;
    assign exp_slice    = expected_tt[dut_in*OUT_W +: OUT_W];

    // Number of output bits that agree with the expected slice.
    always_comb begin
        match = '0;
        for (int i = 0; i < OUT_W; i++) begin
            match = match + MATCH_W'(~(dut_out[i] ^ exp_slice[i]));
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and status decode
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_start) begin
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (settle_hit) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_vec) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_APPLY;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: vector counter, settle timer, fitness and captured table
    // ------------------------------------------------------------------
    // NOTE: result_tt is a plain flop bank read in parallel, not a RAM, so it
    // can take the synchronous clear on reset and on abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            dut_in     <= '0;
            settle_cnt <= '0;
            fitness    <= '0;
            result_tt  <= '0;
            perfect    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_start) begin
                        dut_in     <= '0;
                        settle_cnt <= '0;
                        fitness    <= '0;
                        result_tt  <= '0;
                        perfect    <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (abort) begin
                        settle_cnt <= '0;
                        fitness    <= '0;
                        result_tt  <= '0;
                        perfect    <= 1'b0;
                    end else begin
                        // Wraps harmlessly on the hit cycle; SAMPLE clears it.
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        settle_cnt <= '0;
                        fitness    <= '0;
                        result_tt  <= '0;
                        perfect    <= 1'b0;
                    end else begin
                        fitness                          <= fitness + FIT_W'(match);
                        result_tt[dut_in*OUT_W +: OUT_W] <= dut_out;
                        settle_cnt                       <= '0;
                        // dut_in parks on the last vector rather than wrapping.
                        if (!last_vec) begin
                            dut_in <= dut_in + IN_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    perfect <= (fitness == FIT_W'(TT_W));
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ga_eval_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ga_eval_sequencer
//
// Directed and randomized bench for ga_eval_sequencer. Two instances are used:
// the default configuration (IN_W=4, OUT_W=2, SETTLE=8) and a small one
// (IN_W=2, OUT_W=1, SETTLE=1). The array under test is modelled as a lookup
// table. Expected fitness and truth tables come from a bit-counting model over
// that table.
// ---------------------------------------------------------------------------
module tb_ga_eval_sequencer;

    localparam int IN_W   = 4;
    localparam int OUT_W  = 2;
    localparam int SETTLE = 8;
    localparam int FIT_W  = 8;
    localparam int NVEC   = 1 << IN_W;
    localparam int TT_W   = NVEC * OUT_W;
    localparam int LAT    = 1 + NVEC * (SETTLE + 1);

    localparam int S_IN_W   = 2;
    localparam int S_OUT_W  = 1;
    localparam int S_SETTLE = 1;
    localparam int S_FIT_W  = 4;
    localparam int S_NVEC   = 1 << S_IN_W;
    localparam int S_TT_W   = S_NVEC * S_OUT_W;
    localparam int S_LAT    = 1 + S_NVEC * (S_SETTLE + 1);

    logic FPGA_CLK1_50 = 1'b0;
    always #5 FPGA_CLK1_50 = ~FPGA_CLK1_50;

    // Default-configuration instance
    logic              reset;
    logic              start;
    logic              abort;
    logic [TT_W-1:0]   expected_tt;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  dut_out;
    logic [TT_W-1:0]   result_tt;
    logic [FIT_W-1:0]  fitness;
    logic              perfect;
    logic              busy;
    logic              done;

    logic [OUT_W-1:0]  lut [NVEC];
    assign dut_out = lut[dut_in];

    ga_eval_sequencer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SETTLE(SETTLE),
        .FIT_W (FIT_W)
    ) u_dut (
        .clk        (FPGA_CLK1_50),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .expected_tt(expected_tt),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .result_tt  (result_tt),
        .fitness    (fitness),
        .perfect    (perfect),
        .busy       (busy),
        .done       (done)
    );

    // Small-configuration instance: the array is a parity function
    logic                reset_s;
    logic                start_s;
    logic                abort_s;
    logic [S_TT_W-1:0]   expected_tt_s;
    logic [S_IN_W-1:0]   dut_in_s;
    logic [S_OUT_W-1:0]  dut_out_s;
    logic [S_TT_W-1:0]   result_tt_s;
    logic [S_FIT_W-1:0]  fitness_s;
    logic                perfect_s;
    logic                busy_s;
    logic                done_s;

    assign dut_out_s = ^dut_in_s;

    ga_eval_sequencer #(
        .IN_W  (S_IN_W),
        .OUT_W (S_OUT_W),
        .SETTLE(S_SETTLE),
        .FIT_W (S_FIT_W)
    ) u_small (
        .clk        (FPGA_CLK1_50),
        .reset      (reset_s),
        .start      (start_s),
        .abort      (abort_s),
        .expected_tt(expected_tt_s),
        .dut_in     (dut_in_s),
        .dut_out    (dut_out_s),
        .result_tt  (result_tt_s),
        .fitness    (fitness_s),
        .perfect    (perfect_s),
        .busy       (busy_s),
        .done       (done_s)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge FPGA_CLK1_50);
    endtask

    // Reference model: count equal bits between the lookup table and expected_tt.
    function automatic int model_fitness();
        int n = 0;
        for (int v = 0; v < NVEC; v++) begin
            for (int b = 0; b < OUT_W; b++) begin
                if (lut[v][b] == expected_tt[v*OUT_W + b]) n++;
            end
        end
        return n;
    endfunction

    function automatic logic [TT_W-1:0] model_tt();
        logic [TT_W-1:0] r = '0;
        for (int v = 0; v < NVEC; v++) begin
            r[v*OUT_W +: OUT_W] = lut[v];
        end
        return r;
    endfunction

    // Runs one evaluation on the default instance. Start goes high in cycle 0.
    // abort_at and re_a/re_b give the cycle of an abort or extra start pulse
    // (0 means none).
    task automatic run_big(input string tag, input int abort_at, input int re_a, input int re_b);
        int              done_k;
        int              done_cnt;
        int              lim;
        int              e_fit;
        logic [TT_W-1:0] e_tt;
        e_fit    = model_fitness();
        e_tt     = model_tt();
        lim      = (abort_at > 0) ? abort_at + 201 : LAT + 5;
        done_k   = -1;
        done_cnt = 0;
        start    = 1'b1;
        abort    = 1'b0;
        for (int k = 1; k <= lim; k++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (abort_at == 0) begin
                if (k < LAT) begin
                    check({tag, " dut_in"}, 64'(dut_in), 64'((k - 1) / (SETTLE + 1)));
                    check({tag, " busy"}, 64'(busy), 64'd1);
                end else if (k == LAT) begin
                    check({tag, " busy_in_done"}, 64'(busy), 64'd0);
                    check({tag, " done_at_latency"}, 64'(done), 64'd1);
                end
            end else if (k == abort_at + 1) begin
                check({tag, " busy_after_abort"}, 64'(busy), 64'd0);
                check({tag, " fitness_after_abort"}, 64'(fitness), 64'd0);
                check({tag, " result_after_abort"}, 64'(result_tt), 64'd0);
                check({tag, " perfect_after_abort"}, 64'(perfect), 64'd0);
            end
            if (k == abort_at) abort = 1'b1;
            if (k == re_a || k == re_b) start = 1'b1;
        end
        check({tag, " busy_final"}, 64'(busy), 64'd0);
        if (abort_at == 0) begin
            check({tag, " done_cycle"}, 64'(done_k), 64'(LAT));
            check({tag, " done_count"}, 64'(done_cnt), 64'd1);
            check({tag, " fitness"}, 64'(fitness), 64'(e_fit));
            check({tag, " result_tt"}, 64'(result_tt), 64'(e_tt));
            check({tag, " perfect"}, 64'(perfect), 64'(e_fit == TT_W));
            check({tag, " dut_in_park"}, 64'(dut_in), 64'(NVEC - 1));
        end else begin
            check({tag, " done_count"}, 64'(done_cnt), 64'd0);
            check({tag, " fitness_idle"}, 64'(fitness), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int               s_done_k;
        int               s_done_cnt;
        int               s_fit;
        logic [S_TT_W-1:0] s_tt;
        logic [IN_W-1:0]  vv;

        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        expected_tt   = '0;
        reset_s       = 1'b1;
        start_s       = 1'b0;
        abort_s       = 1'b0;
        expected_tt_s = '0;
        for (int v = 0; v < NVEC; v++) lut[v] = '0;
        repeat (3) tick();
        reset   = 1'b0;
        reset_s = 1'b0;

        // Idle after reset: nothing moves without start.
        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle busy", 64'(busy), 64'd0);
            check("idle done", 64'(done), 64'd0);
        end
        check("reset dut_in", 64'(dut_in), 64'd0);
        check("reset result_tt", 64'(result_tt), 64'd0);
        check("reset fitness", 64'(fitness), 64'd0);
        check("reset perfect", 64'(perfect), 64'd0);
        check("reset small busy", 64'(busy_s), 64'd0);
        check("reset small fitness", 64'(fitness_s), 64'd0);

        // Identity-like array against a matching expected table.
        for (int v = 0; v < NVEC; v++) begin
            vv     = IN_W'(v);
            lut[v] = vv[1:0];
        end
        expected_tt = 32'hE4E4_E4E4;
        run_big("ident", 0, 0, 0);
        check("ident fitness_const", 64'(fitness), 64'd32);

        // Stuck-at-zero array against alternating expected bits.
        for (int v = 0; v < NVEC; v++) lut[v] = '0;
        expected_tt = 32'hAAAA_AAAA;
        run_big("zero", 0, 0, 0);
        check("zero fitness_const", 64'(fitness), 64'd16);

        // Random arrays and expected tables; the last one expects perfection.
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < NVEC; v++) lut[v] = OUT_W'($urandom_range(0, 3));
            expected_tt = (r == 3) ? model_tt() : TT_W'($urandom);
            run_big($sformatf("rand%0d", r), 0, 0, 0);
        end

        // Abort mid-run, then restart with the identity stimulus.
        for (int v = 0; v < NVEC; v++) begin
            vv     = IN_W'(v);
            lut[v] = vv[1:0];
        end
        expected_tt = 32'hE4E4_E4E4;
        run_big("abort", 50, 0, 0);
        run_big("restart", 0, 0, 0);

        // Start re-pulsed while busy, and again in the DONE cycle: both ignored.
        run_big("repulse", 0, 10, 100);
        run_big("start_in_done", 0, LAT, 0);

        // Start together with abort in IDLE is refused.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("start_abort busy", 64'(busy), 64'd0);
        end

        // Small configuration: parity array against its own truth table.
        expected_tt_s = 4'b0110;
        s_fit = 0;
        s_tt  = '0;
        for (int v = 0; v < S_NVEC; v++) begin
            vv      = IN_W'(v);
            s_tt[v] = ^vv;
            if (s_tt[v] == expected_tt_s[v]) s_fit++;
        end
        s_done_k   = -1;
        s_done_cnt = 0;
        start_s    = 1'b1;
        for (int k = 1; k <= S_LAT + 3; k++) begin
            tick();
            start_s = 1'b0;
            if (done_s) begin
                s_done_cnt++;
                if (s_done_k < 0) s_done_k = k;
            end
        end
        check("small done_cycle", 64'(s_done_k), 64'(S_LAT));
        check("small done_count", 64'(s_done_cnt), 64'd1);
        check("small fitness", 64'(fitness_s), 64'(s_fit));
        check("small fitness_const", 64'(fitness_s), 64'd4);
        check("small result_tt", 64'(result_tt_s), 64'(s_tt));
        check("small perfect", 64'(perfect_s), 64'd1);

        // Reset mid-run on the small instance.
        s_done_cnt = 0;
        start_s    = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            start_s = 1'b0;
            if (done_s) s_done_cnt++;
            if (k == 6) begin
                reset_s = 1'b0;
                check("small_rst busy", 64'(busy_s), 64'd0);
                check("small_rst dut_in", 64'(dut_in_s), 64'd0);
                check("small_rst result_tt", 64'(result_tt_s), 64'd0);
                check("small_rst fitness", 64'(fitness_s), 64'd0);
                check("small_rst perfect", 64'(perfect_s), 64'd0);
            end
            if (k == 5) reset_s = 1'b1;
        end
        check("small_rst done_count", 64'(s_done_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
